// File: rtl/ddfs_tuning_word_bank_if.sv
// Bus bundle for ddfs_tuning_word_bank: shadow write port, commit handshake and active outputs.
interface ddfs_tuning_word_bank_if #(
  parameter int WIDTH    = 48,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 2
);
  logic                      Wr_En;
  logic [ADDR_W-1:0]         Wr_Addr;
  logic [WIDTH-1:0]          Wr_Data;
  logic                      Commit_Req;
  logic                      Commit_Mode;
  logic                      Sync;
  logic                      Busy;
  logic                      Done;
  logic [CHANNELS-1:0]       Pending;
  logic [CHANNELS*WIDTH-1:0] Dout;

  modport master (
    output Wr_En, Wr_Addr, Wr_Data, Commit_Req, Commit_Mode, Sync,
    input  Busy, Done, Pending, Dout
  );

  modport slave (
    input  Wr_En, Wr_Addr, Wr_Data, Commit_Req, Commit_Mode, Sync,
    output Busy, Done, Pending, Dout
  );
endinterface

// File: rtl/ddfs_tuning_word_bank.sv
// Double-buffered multi-channel DDFS tuning-word bank with coherent commit.
// Define DDFS_RAMP_EN to slew active words toward the committed targets by RAMP_STEP per cycle.
module ddfs_tuning_word_bank #(
  parameter int               WIDTH     = 48,
  parameter int               CHANNELS  = 4,
  parameter int               ADDR_W    = 2,
  parameter logic [WIDTH-1:0] RAMP_STEP = 48'd1
) (
  input logic                    Clock,
  input logic                    Reset,
  ddfs_tuning_word_bank_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    APPLY     = 2'd2
  } state_t;

  if ((RAMP_STEP == '0) || ((2 ** ADDR_W) < CHANNELS)) begin : g_bad_cfg
    $error("ddfs_tuning_word_bank: invalid RAMP_STEP or ADDR_W");
  end

  state_t              state_r;
  state_t              state_nxt_s;
  logic                busy_r;
  logic                done_r;
  logic                busy_nxt_s;
  logic                done_nxt_s;
  logic                enter_apply_s;
  logic                apply_done_s;
  logic                pend_clr_s;
  logic [CHANNELS-1:0] wr_hit_s;
  logic [CHANNELS-1:0] pending_r;
  logic [WIDTH-1:0]    shadow_r [CHANNELS];
  logic [WIDTH-1:0]    active_r [CHANNELS];

  // Write address decode; out-of-range addresses hit no channel
  always_comb begin
    wr_hit_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.Wr_En && (bus.Wr_Addr == ADDR_W'(c))) wr_hit_s[c] = 1'b1;
      else wr_hit_s[c] = 1'b0;
    end
  end

`ifdef DDFS_RAMP_EN
  logic [WIDTH-1:0] target_r [CHANNELS];
  logic [WIDTH-1:0] step_s   [CHANNELS];
  logic             ramp_done_s;

  // Clamped one-step move of every active word toward its target
  always_comb begin
    step_s      = active_r;
    ramp_done_s = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (target_r[c] > active_r[c]) begin
        if ((target_r[c] - active_r[c]) <= RAMP_STEP) step_s[c] = target_r[c];
        else step_s[c] = active_r[c] + RAMP_STEP;
      end else if (target_r[c] < active_r[c]) begin
        if ((active_r[c] - target_r[c]) <= RAMP_STEP) step_s[c] = target_r[c];
        else step_s[c] = active_r[c] - RAMP_STEP;
      end else begin
        step_s[c] = active_r[c];
      end
      if (step_s[c] != target_r[c]) ramp_done_s = 1'b0;
      else ramp_done_s = ramp_done_s;
    end
  end

  assign apply_done_s = ramp_done_s;
  assign pend_clr_s   = enter_apply_s;
`else
  assign apply_done_s = 1'b1;
  assign pend_clr_s   = (state_r == APPLY);
`endif

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Commit_Req) state_nxt_s = bus.Commit_Mode ? WAIT_SYNC : APPLY;
        else state_nxt_s = IDLE;
      end
      WAIT_SYNC: begin
        if (bus.Sync) state_nxt_s = APPLY;
        else state_nxt_s = WAIT_SYNC;
      end
      APPLY: begin
        if (apply_done_s) state_nxt_s = IDLE;
        else state_nxt_s = APPLY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode feeding the registered flags
  always_comb begin
    busy_nxt_s    = (state_nxt_s != IDLE);
    done_nxt_s    = (state_r == APPLY) && apply_done_s;
    enter_apply_s = (state_r != APPLY) && (state_nxt_s == APPLY);
  end

  // Registered handshake flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Shadow words and pending flags; a same-edge write wins over the clear
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pending_r <= '0;
      for (int c = 0; c < CHANNELS; c++) shadow_r[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_hit_s[c]) begin
          shadow_r[c]  <= bus.Wr_Data;
          pending_r[c] <= 1'b1;
        end else if (pend_clr_s) begin
          pending_r[c] <= 1'b0;
        end
      end
    end
  end

  // Active words: sampled from the pre-edge shadows so coincident writes wait for the next commit
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int c = 0; c < CHANNELS; c++) active_r[c] <= '0;
`ifdef DDFS_RAMP_EN
      for (int c = 0; c < CHANNELS; c++) target_r[c] <= '0;
    end else begin
      if (enter_apply_s) target_r <= shadow_r;
      if (state_r == APPLY) active_r <= step_s;
    end
`else
    end else begin
      if (state_r == APPLY) active_r <= shadow_r;
    end
`endif
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_dout
    assign bus.Dout[c*WIDTH +: WIDTH] = active_r[c];
  end

  assign bus.Busy    = busy_r;
  assign bus.Done    = done_r;
  assign bus.Pending = pending_r;

endmodule

// File: tb/tb_ddfs_tuning_word_bank.sv
// Scoreboard bench for ddfs_tuning_word_bank: expected Dout pushed at commit, checked on each Done pulse.
module tb_ddfs_tuning_word_bank;
  localparam int W = 48;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  ddfs_tuning_word_bank_if #(.WIDTH(W), .CHANNELS(4), .ADDR_W(2)) bus ();
  ddfs_tuning_word_bank_if #(.WIDTH(W), .CHANNELS(3), .ADDR_W(2)) bus3 ();

  ddfs_tuning_word_bank #(.WIDTH(W), .CHANNELS(4), .ADDR_W(2), .RAMP_STEP(48'd4)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );
  ddfs_tuning_word_bank #(.WIDTH(W), .CHANNELS(3), .ADDR_W(2), .RAMP_STEP(48'd1)) dut3 (
    .Clock(Clock), .Reset(Reset), .bus(bus3)
  );

  assign bus3.Wr_En       = bus.Wr_En;
  assign bus3.Wr_Addr     = bus.Wr_Addr;
  assign bus3.Wr_Data     = bus.Wr_Data;
  assign bus3.Commit_Req  = bus.Commit_Req;
  assign bus3.Commit_Mode = bus.Commit_Mode;
  assign bus3.Sync        = bus.Sync;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int dc0;
  logic [W-1:0]   m_sh [4];
  logic [4*W-1:0] exp_q [$];
  logic [4*W-1:0] prev;
  logic [4*W-1:0] full;
  logic [3*W-1:0] low3;

  task automatic check_val(input string tag, input logic [4*W-1:0] got, input logic [4*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*W-1:0] model_pack();
    logic [4*W-1:0] r;
    for (int c = 0; c < 4; c++) r[c*W +: W] = m_sh[c];
    return r;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input int ch, input logic [W-1:0] d);
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = ch[1:0];
    bus.Wr_Data = d;
    tick();
    bus.Wr_En = 1'b0;
    m_sh[ch] = d;
  endtask

  task automatic commit(input logic mode, input logic with_sync);
    bus.Commit_Req  = 1'b1;
    bus.Commit_Mode = mode;
    bus.Sync        = with_sync;
    tick();
    bus.Commit_Req = 1'b0;
    bus.Sync       = 1'b0;
  endtask

  // Scoreboard: every Done pulse consumes one expected Dout
  always @(negedge Clock) begin
    if (bus.Done === 1'b1) begin
      done_cnt++;
      check_val("done_with_busy", bus.Busy, 1'b0);
      check_val("done_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) check_val("dout_at_done", bus.Dout, exp_q.pop_front());
    end
  end

  initial begin
    bus.Wr_En = 1'b0; bus.Wr_Addr = 2'd0; bus.Wr_Data = '0;
    bus.Commit_Req = 1'b0; bus.Commit_Mode = 1'b0; bus.Sync = 1'b0;
    for (int c = 0; c < 4; c++) m_sh[c] = '0;
    tick(); tick();
    Reset = 1'b0;
    check_val("rst_dout", bus.Dout, '0);
    check_val("rst_busy", bus.Busy, 1'b0);
    check_val("rst_done", bus.Done, 1'b0);
    check_val("rst_pending", bus.Pending, 4'b0000);

`ifndef DDFS_RAMP_EN
    // Immediate commit of ch0 and ch2
    wr(0, 48'h0000_0001_0000);
    wr(2, 48'h1234_5678_9ABC);
    check_val("imm_pending_pre", bus.Pending, 4'b0101);
    exp_q.push_back(model_pack());
    commit(1'b0, 1'b0);
    check_val("imm_busy_k", bus.Busy, 1'b1);
    check_val("imm_dout_k", bus.Dout, '0);
    tick();
    check_val("imm_dout_k1", bus.Dout, model_pack());
    check_val("imm_done_k1", bus.Done, 1'b1);
    check_val("imm_pending_post", bus.Pending, 4'b0000);
    tick();
    check_val("imm_done_k2", bus.Done, 1'b0);

    // Sync commit: coincident Sync ignored, extra Commit_Req dropped
    prev = model_pack();
    wr(3, 48'h0000_0000_0777);
    exp_q.push_back(model_pack());
    dc0 = done_cnt;
    commit(1'b1, 1'b1);
    check_val("wait_busy0", bus.Busy, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) bus.Commit_Req = 1'b1;
      tick();
      bus.Commit_Req = 1'b0;
      check_val("wait_busy", bus.Busy, 1'b1);
      check_val("wait_dout", bus.Dout, prev);
    end
    bus.Sync = 1'b1;
    tick();
    bus.Sync = 1'b0;
    check_val("sync_edge_dout", bus.Dout, prev);
    tick();
    check_val("sync_apply_dout", bus.Dout, model_pack());
    check_val("sync_done", bus.Done, 1'b1);
    tick(); tick(); tick();
    check_val("single_done", done_cnt, dc0 + 1);

    // Write coincident with the apply edge
    wr(1, 48'h5555);
    exp_q.push_back(model_pack());
    commit(1'b0, 1'b0);
    bus.Wr_En = 1'b1; bus.Wr_Addr = 2'd1; bus.Wr_Data = 48'hAAAA;
    tick();
    bus.Wr_En = 1'b0;
    full = bus.Dout;
    check_val("coinc_ch1", full[2*W-1:W], 48'h5555);
    check_val("coinc_pending", bus.Pending, 4'b0010);
    m_sh[1] = 48'hAAAA;
    exp_q.push_back(model_pack());
    commit(1'b0, 1'b0);
    tick();
    full = bus.Dout;
    check_val("next_ch1", full[2*W-1:W], 48'hAAAA);
    check_val("next_pending", bus.Pending, 4'b0000);

    // Address 3 ignored by the 3-channel instance
    wr(3, 48'hBEEF);
    check_val("ch3_pending4", bus.Pending, 4'b1000);
    check_val("ch3_pending3", bus3.Pending, 3'b000);
    exp_q.push_back(model_pack());
    commit(1'b0, 1'b0);
    tick();
    full = model_pack();
    low3 = full[3*W-1:0];
    check_val("ch3_dout3", bus3.Dout, low3);
    check_val("ch3_done3", bus3.Done, 1'b1);
`else
    // Ramp up 0 -> 10 then down 10 -> 1 with step 4
    wr(0, 48'd10);
    exp_q.push_back(model_pack());
    commit(1'b0, 1'b0);
    check_val("ramp_busy", bus.Busy, 1'b1);
    check_val("ramp_pending", bus.Pending, 4'b0000);
    tick(); check_val("ramp_up4", bus.Dout, 48'd4);
    check_val("ramp_busy4", bus.Busy, 1'b1);
    tick(); check_val("ramp_up8", bus.Dout, 48'd8);
    tick(); check_val("ramp_up10", bus.Dout, 48'd10);
    check_val("ramp_up_done", bus.Done, 1'b1);
    tick();
    wr(0, 48'd1);
    exp_q.push_back(model_pack());
    commit(1'b0, 1'b0);
    tick(); check_val("ramp_dn6", bus.Dout, 48'd6);
    tick(); check_val("ramp_dn2", bus.Dout, 48'd2);
    tick(); check_val("ramp_dn1", bus.Dout, 48'd1);
    check_val("ramp_dn_done", bus.Done, 1'b1);
    tick();
`endif

    // Reset during WAIT_SYNC aborts with no update and no Done
    wr(2, 48'hFFFF);
    dc0 = done_cnt;
    commit(1'b1, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) m_sh[c] = '0;
    check_val("abort_dout", bus.Dout, '0);
    check_val("abort_busy", bus.Busy, 1'b0);
    check_val("abort_pending", bus.Pending, 4'b0000);
    check_val("abort_done", bus.Done, 1'b0);
    bus.Sync = 1'b1;
    tick();
    bus.Sync = 1'b0;
    tick(); tick();
    check_val("abort_no_done", done_cnt, dc0);
    check_val("abort_dout2", bus.Dout, '0);
    exp_q.push_back(model_pack());
    commit(1'b0, 1'b0);
    tick();
    check_val("post_abort_dout", bus.Dout, '0);
    check_val("post_abort_done", bus.Done, 1'b1);
    tick(); tick();
    check_val("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddfs_tuning_word_bank.md
Name: ddfs_tuning_word_bank

Overview:
- Multi-channel, double-buffered tuning-word register bank for the DDFS phase accumulators.
- Generalises the single 48-bit enabled load register.
- Software writes per-channel shadow words at any time; a commit transfers all shadows to the active outputs together, either immediately or aligned to a Sync pulse (e.g. accumulator wrap).
- Guarantees glitch-free, channel-coherent frequency changes.

Parameters:
- WIDTH, 48, tuning-word width in bits.
- CHANNELS, 4, number of DDFS channels.
- ADDR_W, 2, channel address width; must satisfy 2**ADDR_W >= CHANNELS.
- RAMP_STEP, 48'd1, per-cycle increment used only when DDFS_RAMP_EN is defined; must be >= 1.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  synchronous reset, active-high.
- Wr_En  input  1  shadow write strobe.
- Wr_Addr  input  ADDR_W  channel select for the write; addresses >= CHANNELS are ignored.
- Wr_Data  input  WIDTH  shadow word.
- Commit_Req  input  1  commit request, single-cycle; ignored while Busy.
- Commit_Mode  input  1  0 = immediate, 1 = wait for Sync; sampled with Commit_Req.
- Sync  input  1  alignment pulse.
- Busy  output  1  commit in progress.
- Done  output  1  one-cycle pulse when the commit has completed.
- Pending  output  CHANNELS  per-channel flag: shadow written since the last apply.
- Dout  output  CHANNELS*WIDTH  active words; channel c occupies bits [c*WIDTH +: WIDTH].

Behaviour:
- Reset (synchronous, Reset=1 at an edge):
  - All shadow and active words cleared to 0.
  - Pending=0, Busy=0, Done=0, FSM=IDLE.
  - Reset mid-commit aborts the commit with no partial update.
- Shadow write: at an edge with Wr_En=1 and a valid Wr_Addr:
  - shadow[Wr_Addr] <= Wr_Data.
  - Pending[Wr_Addr] <= 1.
  - Writes are accepted in every state.
- FSM states: IDLE, WAIT_SYNC, APPLY.
  - IDLE: Commit_Req=1 at an edge → Busy<=1. Go to APPLY if Commit_Mode=0, or WAIT_SYNC if Commit_Mode=1.
  - WAIT_SYNC: Sync=1 at an edge → APPLY. A Sync coincident with the accepting Commit_Req edge does not count. Waits indefinitely with no timeout.
  - APPLY (no ramp):
    - At the next edge all active words <= shadow words simultaneously.
    - Pending <= 0, except any bit whose shadow is written at that same edge; that bit stays 1.
    - Busy <= 0, Done <= 1 for one cycle, return to IDLE.
- Latency:
  - Immediate mode: Commit_Req seen at edge k → Dout updated at edge k+1, Done high between edges k+1 and k+2.
  - Sync mode: Sync seen at edge j → Dout updated at edge j+1.
- Write coincident with the apply edge: the apply uses the old shadow value; the new value remains in shadow for the next commit.
- Commit_Req while Busy=1 is dropped and not queued.
- Done is never asserted together with Busy=1.
- Dout is registered; no combinational path from any input to Dout.

Optional Feature:
- Macro: DDFS_RAMP_EN.
- Defined:
  - On entry to APPLY, shadows are snapshotted as targets.
  - Each cycle, every active word moves toward its target by RAMP_STEP (unsigned, up or down).
  - The step clamps to the target and never overshoots or wraps.
  - Busy stays high until all channels equal their targets; Done then pulses.
  - Pending clears at snapshot time.
  - Writes during the ramp affect only the next commit.
  - A channel already at its target does not move.
- Undefined: APPLY performs the single-cycle copy described in Behaviour. RAMP_STEP is unused.

Test Plan:
- Reset, then write ch0=48'h0000_0001_0000 and ch2=48'h1234_5678_9ABC, immediate commit at edge k:
  - Dout ch0/ch2 show the values at edge k+1.
  - ch1 and ch3 remain 0.
  - Pending=4'b0101 before the commit, 0 after; Done is a single pulse.
- Sync-mode commit with Sync held low for 20 cycles:
  - Dout unchanged and Busy=1 throughout.
  - Sync pulse at edge j → Dout updated at edge j+1.
  - Sync coincident with Commit_Req is ignored.
- Write ch1=48'hAAAA at the same edge the apply occurs (shadow ch1 previously 48'h5555):
  - Dout ch1=48'h5555, Pending[1]=1.
  - Next commit yields 48'hAAAA.
- Commit_Req pulsed again while in WAIT_SYNC: no effect, only one Done pulse; Wr_Addr=3 with CHANNELS=3 is ignored.
- Reset asserted during WAIT_SYNC with shadows nonzero: all Dout=0, Busy=0, Pending=0, and no Done.
- DDFS_RAMP_EN, RAMP_STEP=4, ch0 active 0 → target 10:
  - Dout ch0 = 4, 8, 10 on successive edges, then Done.
  - A downward ramp 10 → 1 gives 6, 2, 1.
